mix_columns_iter: RTL

Iterative, parametrised MixColumns engine that performs either the forward (MixColumns) or inverse (InvMixColumns) AES column transform on a 128-bit state. The transform mode is selected per transaction. It replaces the single-direction, purely combinational inverse column mixer in the round datapath. It processes COLS_PER_CYCLE columns per clock, trading area for latency. Valid/ready handshakes on input and output let the round controller stall it.

---
 rtl/mix_columns_if.sv | 22 ++
 rtl/mix_columns_iter.sv | 137 +++++++++++++
 2 files changed

// File: rtl/mix_columns_if.sv
// Handshake bundle for the iterative MixColumns engine: an input valid/ready
// channel carrying state and mode, and an output valid/ready channel carrying the result.
interface mix_columns_if;
  logic         in_valid;
  logic         in_ready;
  logic         in_inv;
  logic [127:0] in_state;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic         busy;

  modport slave (
    input  in_valid, in_inv, in_state, out_ready,
    output in_ready, out_valid, out_state, busy
  );

  modport master (
    output in_valid, in_inv, in_state, out_ready,
    input  in_ready, out_valid, out_state, busy
  );
endinterface

// File: rtl/mix_columns_iter.sv
// Iterative forward/inverse AES MixColumns: transforms COLS_PER_CYCLE columns of
// the working register per BUSY cycle, most-significant column first.
module mix_columns_iter #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  mix_columns_if.slave bus
);

  localparam logic [1:0] STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST = 2'(4 - COLS_PER_CYCLE);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
    $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [1:0]   col_cnt_q, col_cnt_d;
  logic [127:0] wreg_q, wreg_d;
  logic         mreg_q, mreg_d;

  logic         in_ready_c;
  logic         out_valid_c;
  logic         busy_c;
  logic [1:0]   idx;
  logic [6:0]   base;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Every constant multiplier is a XOR of the x1/x2/x4/x8 multiples of the byte.
  function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
    logic [7:0] s  [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      s[i]  = col[31-8*i -: 8];
      x2[i] = xtime(s[i]);
      x4[i] = xtime(x2[i]);
      x8[i] = xtime(x4[i]);
    end
    for (int i = 0; i < 4; i++) begin
      if (inv) begin
        r[31-8*i -: 8] = (x8[i] ^ x4[i] ^ x2[i])
                       ^ (x8[(i+1)%4] ^ x2[(i+1)%4] ^ s[(i+1)%4])
                       ^ (x8[(i+2)%4] ^ x4[(i+2)%4] ^ s[(i+2)%4])
                       ^ (x8[(i+3)%4] ^ s[(i+3)%4]);
      end else begin
        r[31-8*i -: 8] = x2[i]
                       ^ (x2[(i+1)%4] ^ s[(i+1)%4])
                       ^ s[(i+2)%4]
                       ^ s[(i+3)%4];
      end
    end
    return r;
  endfunction

  always_comb begin
    state_d     = state_q;
    col_cnt_d   = col_cnt_q;
    wreg_d      = wreg_q;
    mreg_d      = mreg_q;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    busy_c      = 1'b0;
    idx         = '0;
    base        = '0;
    case (state_q)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          wreg_d    = bus.in_state;
          mreg_d    = bus.in_inv;
          col_cnt_d = '0;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        busy_c = 1'b1;
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
          idx  = col_cnt_q + 2'(k);
          base = 7'd127 - {idx, 5'd0};
          wreg_d[base -: 32] = mix_col(wreg_q[base -: 32], mreg_q);
        end
        col_cnt_d = col_cnt_q + STEP;
        if (col_cnt_q == LAST) state_d = DONE;
      end
      DONE: begin
        out_valid_c = 1'b1;
        in_ready_c  = bus.out_ready;
        // A new input may be taken on the same edge the result leaves.
        if (bus.out_ready) begin
          if (bus.in_valid) begin
            wreg_d    = bus.in_state;
            mreg_d    = bus.in_inv;
            col_cnt_d = '0;
            state_d   = BUSY;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      col_cnt_q <= '0;
      wreg_q    <= '0;
      mreg_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_cnt_q <= col_cnt_d;
      wreg_q    <= wreg_d;
      mreg_q    <= mreg_d;
    end
  end

  assign bus.in_ready  = in_ready_c & rst_n;
  assign bus.out_valid = out_valid_c;
  assign bus.busy      = busy_c;
  assign bus.out_state = wreg_q;

endmodule
